// File: rtl/dmux_pkg.sv
// Shared types and helpers for the three-source read-return arbiter.
package dmux_pkg;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_STREAM = 2'd1,
    SRC_NET    = 2'd2,
    SRC_LOCAL  = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STARVED
  } starve_e;

  localparam int unsigned DataW   = 64;
  localparam int unsigned MaxTagW = 32;
  localparam int unsigned MaxBusW = MaxTagW + DataW;

  // Callers zero-extend their {tag, data} bus to MaxBusW and truncate the tag.
  function automatic logic [MaxTagW-1:0] tag_of(input logic [MaxBusW-1:0] bus);
    return bus[MaxBusW-1:DataW];
  endfunction

  function automatic logic [DataW-1:0] data_of(input logic [MaxBusW-1:0] bus);
    return bus[DataW-1:0];
  endfunction

endpackage

// File: rtl/dmux_starve_cnt.sv
// Saturating lost-arbitration counter for one low-priority source.
module dmux_starve_cnt
  import dmux_pkg::*;
#(
  parameter int unsigned Limit = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic drdy,
  input  logic stall,
  input  logic grant,
  output logic starved
);

  localparam int unsigned CntW = (Limit > 0) ? $clog2(Limit + 1) : 1;
  localparam logic [CntW-1:0] Max = CntW'(Limit);

  logic [CntW-1:0] count;
  starve_e         state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      state <= ST_IDLE;
    end else if (!drdy || grant) begin
      count <= '0;
      state <= ST_IDLE;
    end else if (!stall) begin
      if (count != Max) count <= count + CntW'(1);
      // STARVED is entered on the same edge the count reaches the limit.
      state <= (Limit != 0 && count >= Max - CntW'(1)) ? ST_STARVED : ST_WAIT;
    end else if (state == ST_IDLE) begin
      state <= ST_WAIT;
    end
  end

  assign starved = (state == ST_STARVED);

endmodule

// File: rtl/dmux_arbiter.sv
// Stream/Net/Local read-return arbiter: fixed priority with starvation promotion.
module dmux_arbiter
  import dmux_pkg::*;
#(
  parameter int unsigned TagWidth    = 10,
  parameter int unsigned StarveLimit = 15,
  parameter int unsigned DataLag     = 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      StreamDRDY,
  input  logic [TagWidth+DataW-1:0] StreamDATA,
  output logic                      StreamRD,
  input  logic                      NetDRDY,
  input  logic [TagWidth+DataW-1:0] NetDATA,
  output logic                      NetRD,
  input  logic                      LocalDRDY,
  input  logic [TagWidth+DataW-1:0] LocalDATA,
  output logic                      LocalRD,
  input  logic                      STALL,
  output logic                      DRDY,
  output logic [TagWidth-1:0]       TAG,
  output logic [DataW-1:0]          DATA,
  output logic [1:0]                GrantSrc
);

  logic                net_starved;
  logic                local_starved;
  src_e                sel;
  src_e                src_q;
  logic [TagWidth-1:0] sel_tag;
  logic [DataW-1:0]    sel_data;

  dmux_starve_cnt #(.Limit(StarveLimit)) u_net (
    .clk     (CLK),
    .rst     (RESET),
    .drdy    (NetDRDY),
    .stall   (STALL),
    .grant   (NetRD),
    .starved (net_starved)
  );

  dmux_starve_cnt #(.Limit(StarveLimit)) u_local (
    .clk     (CLK),
    .rst     (RESET),
    .drdy    (LocalDRDY),
    .stall   (STALL),
    .grant   (LocalRD),
    .starved (local_starved)
  );

  // Starved flags are registered, so they are re-qualified with live DRDY.
  always_comb begin
    sel = SRC_NONE;
    if (!RESET && !STALL) begin
      if (LocalDRDY && local_starved)  sel = SRC_LOCAL;
      else if (NetDRDY && net_starved) sel = SRC_NET;
      else if (StreamDRDY)             sel = SRC_STREAM;
      else if (NetDRDY)                sel = SRC_NET;
      else if (LocalDRDY)              sel = SRC_LOCAL;
    end
  end

  assign StreamRD = (sel == SRC_STREAM);
  assign NetRD    = (sel == SRC_NET);
  assign LocalRD  = (sel == SRC_LOCAL);

  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    unique case (sel)
      SRC_STREAM: begin
        sel_tag  = TagWidth'(tag_of(MaxBusW'(StreamDATA)));
        sel_data = data_of(MaxBusW'(StreamDATA));
      end
      SRC_NET: begin
        sel_tag  = TagWidth'(tag_of(MaxBusW'(NetDATA)));
        sel_data = data_of(MaxBusW'(NetDATA));
      end
      SRC_LOCAL: begin
        sel_tag  = TagWidth'(tag_of(MaxBusW'(LocalDATA)));
        sel_data = data_of(MaxBusW'(LocalDATA));
      end
      default: begin
        sel_tag  = '0;
        sel_data = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DRDY  <= 1'b0;
      TAG   <= '0;
      src_q <= SRC_NONE;
    end else begin
      DRDY  <= (sel != SRC_NONE);
      TAG   <= sel_tag;
      src_q <= sel;
    end
  end

  assign GrantSrc = src_q;

  generate
    if (DataLag == 0) begin : g_nolag
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) DATA <= '0;
        else       DATA <= sel_data;
      end
    end else begin : g_lag
      logic [DataW-1:0] data_lag;
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          data_lag <= '0;
          DATA     <= '0;
        end else begin
          data_lag <= sel_data;
          DATA     <= data_lag;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dmux_arbiter.sv
// Directed bench for dmux_arbiter: priority table plus starvation, stall and reset sequences.
module tb_dmux_arbiter;

  localparam logic [73:0] S_BUS = {10'h005, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [73:0] N_BUS = {10'h123, 64'h1111_2222_3333_4444};
  localparam logic [73:0] L_BUS = {10'h00A, 64'hBBBB_BBBB_BBBB_BBBB};

  logic        CLK;
  logic        RESET;
  logic        StreamDRDY, NetDRDY, LocalDRDY, STALL;
  logic [73:0] StreamDATA, NetDATA, LocalDATA;
  logic        StreamRD, NetRD, LocalRD;
  logic        DRDY;
  logic [9:0]  TAG;
  logic [63:0] DATA;
  logic [1:0]  GrantSrc;
  logic        rd0s, rd0n, rd0l;
  logic        drdy0;
  logic [9:0]  tag0;
  logic [63:0] data0;
  logic [1:0]  src0;

  int total = 0;
  int bad   = 0;

  dmux_arbiter #(.TagWidth(10), .StarveLimit(15), .DataLag(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .StreamDRDY(StreamDRDY), .StreamDATA(StreamDATA), .StreamRD(StreamRD),
    .NetDRDY(NetDRDY), .NetDATA(NetDATA), .NetRD(NetRD),
    .LocalDRDY(LocalDRDY), .LocalDATA(LocalDATA), .LocalRD(LocalRD),
    .STALL(STALL), .DRDY(DRDY), .TAG(TAG), .DATA(DATA), .GrantSrc(GrantSrc)
  );

  dmux_arbiter #(.TagWidth(10), .StarveLimit(15), .DataLag(0)) dut0 (
    .CLK(CLK), .RESET(RESET),
    .StreamDRDY(StreamDRDY), .StreamDATA(StreamDATA), .StreamRD(rd0s),
    .NetDRDY(NetDRDY), .NetDATA(NetDATA), .NetRD(rd0n),
    .LocalDRDY(LocalDRDY), .LocalDATA(LocalDATA), .LocalRD(rd0l),
    .STALL(STALL), .DRDY(drdy0), .TAG(tag0), .DATA(data0), .GrantSrc(src0)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct packed {
    logic       stall;
    logic       s;
    logic       n;
    logic       l;
    logic [1:0] src;
  } vec_t;

  vec_t tv [12];

  function automatic logic [2:0] rd_of(input logic [1:0] src);
    case (src)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [9:0] exp_tag(input logic [1:0] src);
    case (src)
      2'd1:    return 10'h005;
      2'd2:    return 10'h123;
      2'd3:    return 10'h00A;
      default: return 10'h000;
    endcase
  endfunction

  function automatic logic [63:0] exp_data(input logic [1:0] src);
    case (src)
      2'd1:    return 64'hAAAA_AAAA_AAAA_AAAA;
      2'd2:    return 64'h1111_2222_3333_4444;
      2'd3:    return 64'hBBBB_BBBB_BBBB_BBBB;
      default: return 64'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic n, input logic l, input logic st);
    StreamDRDY = s;
    NetDRDY    = n;
    LocalDRDY  = l;
    STALL      = st;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string name, input logic d, input logic [9:0] t, input logic [1:0] g);
    chk({name, "_drdy"}, DRDY, d);
    chk({name, "_tag"}, TAG, t);
    chk({name, "_src"}, GrantSrc, g);
  endtask

  logic [1:0] prev1, prev2;

  initial begin
    tv[0]  = 6'b0000_00;
    tv[1]  = 6'b0100_01;
    tv[2]  = 6'b0010_10;
    tv[3]  = 6'b0001_11;
    tv[4]  = 6'b0110_01;
    tv[5]  = 6'b0011_10;
    tv[6]  = 6'b0101_01;
    tv[7]  = 6'b0111_01;
    tv[8]  = 6'b1111_00;
    tv[9]  = 6'b1100_00;
    tv[10] = 6'b0001_11;
    tv[11] = 6'b0000_00;

    RESET      = 1'b1;
    StreamDATA = S_BUS;
    NetDATA    = N_BUS;
    LocalDATA  = L_BUS;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    chk("rst_rd", {StreamRD, NetRD, LocalRD}, 3'b000);
    chk_out("rst", 1'b0, 10'h0, 2'd0);
    chk("rst_data", DATA, 64'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    repeat (2) tick();

    // Single-cycle priority table
    prev1 = 2'd0;
    prev2 = 2'd0;
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].s, tv[i].n, tv[i].l, tv[i].stall);
      #1;
      chk($sformatf("tv%0d_rd", i), {StreamRD, NetRD, LocalRD}, rd_of(tv[i].src));
      chk_out($sformatf("tv%0d", i), prev1 != 2'd0, exp_tag(prev1), prev1);
      chk($sformatf("tv%0d_data", i), DATA, exp_data(prev2));
      chk($sformatf("tv%0d_data0", i), data0, exp_data(prev1));
      prev2 = prev1;
      prev1 = tv[i].src;
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Async reset mid-transfer, between edges
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("pre_rst_drdy", DRDY, 1'b1);
    chk("pre_rst_data", DATA, 64'hAAAA_AAAA_AAAA_AAAA);
    #2 RESET = 1'b1;
    #1;
    chk("arst_rd", {StreamRD, NetRD, LocalRD}, 3'b000);
    chk_out("arst", 1'b0, 10'h0, 2'd0);
    chk("arst_data", DATA, 64'h0);
    chk("arst_data0", data0, 64'h0);
    #1 RESET = 1'b0;
    tick();
    chk_out("rel", 1'b1, 10'h005, 2'd1);
    chk("rel_data", DATA, 64'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Stream beats Local, Local follows
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    #1 chk("p0_rd", {StreamRD, NetRD, LocalRD}, 3'b100);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("p1_rd", {StreamRD, NetRD, LocalRD}, 3'b001);
    chk_out("p1", 1'b1, 10'h005, 2'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("p2_data", DATA, 64'hAAAA_AAAA_AAAA_AAAA);
    chk_out("p2", 1'b1, 10'h00A, 2'd3);
    tick();
    chk("p3_data", DATA, 64'hBBBB_BBBB_BBBB_BBBB);
    chk_out("p3", 1'b0, 10'h0, 2'd0);
    tick();
    chk("p4_data", DATA, 64'h0);
    repeat (2) tick();

    // Local starvation against continuous Stream
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 15; c++) begin
      #1 chk($sformatf("sl%0d_rd", c), {StreamRD, NetRD, LocalRD}, 3'b100);
      tick();
    end
    #1 chk("sl15_rd", {StreamRD, NetRD, LocalRD}, 3'b001);
    tick();
    #1 chk("sl16_rd", {StreamRD, NetRD, LocalRD}, 3'b100);
    chk("sl16_cnt", dut.u_local.count, 4'd0);
    chk_out("sl16", 1'b1, 10'h00A, 2'd3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Net and Local starve together
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 15; c++) tick();
    #1 chk("sb15_rd", {StreamRD, NetRD, LocalRD}, 3'b001);
    tick();
    #1 chk("sb16_rd", {StreamRD, NetRD, LocalRD}, 3'b010);
    chk_out("sb16", 1'b1, 10'h00A, 2'd3);
    tick();
    #1 chk("sb17_rd", {StreamRD, NetRD, LocalRD}, 3'b100);
    chk_out("sb17", 1'b1, 10'h123, 2'd2);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // STALL for cycles 3..7 with all sources valid
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, 1'b1, 1'b1, (c >= 3 && c <= 7));
      #1;
      chk($sformatf("st%0d_rd", c), {StreamRD, NetRD, LocalRD}, (c >= 3 && c <= 7) ? 3'b000 : 3'b100);
      chk($sformatf("st%0d_drdy", c), DRDY, (c >= 1 && c <= 3));
      if (c == 5 || c == 8) begin
        chk($sformatf("st%0d_lcnt", c), dut.u_local.count, 4'd3);
        chk($sformatf("st%0d_ncnt", c), dut.u_net.count, 4'd3);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Zero-lag build: single Net return with all-ones tag
    NetDATA = {10'h3FF, 64'h0123_4567_89AB_CDEF};
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("z0_rd0", {rd0s, rd0n, rd0l}, 3'b010);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("z1_drdy0", drdy0, 1'b1);
    chk("z1_tag0", tag0, 10'h3FF);
    chk("z1_src0", src0, 2'd2);
    chk("z1_data0", data0, 64'h0123_4567_89AB_CDEF);
    chk("z1_data_lag1", DATA, 64'h0);
    tick();
    chk("z2_drdy0", drdy0, 1'b0);
    chk("z2_tag0", tag0, 10'h0);
    chk("z2_src0", src0, 2'd0);
    chk("z2_data0", data0, 64'h0);
    chk("z2_data_lag1", DATA, 64'h0123_4567_89AB_CDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
